// File: rtl/fifo_uart_tx.sv
// Serialises items drained from a fifo (registered data_out) as start/data/stop frames on tx.
// States: IDLE (wait for data) | WAIT (fifo data_out settling) | START | DATA (LSB first) | STOP.
module fifo_uart_tx #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                 CLOCK_50,
    input  logic                 RST,
    input  logic                 enable,
    input  logic [DATA_BITS-1:0] fifo_data,
    input  logic                 fifo_empty,
    output logic                 fifo_read,
    output logic                 tx,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] BIT_LAST  = IW'(DATA_BITS - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;

    logic [2:0]           state_q, state_d;
    logic [BW-1:0]        baud_q, baud_d;
    logic [IW-1:0]        bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] sreg_q, sreg_d;
    logic                 tx_q, tx_d;
    logic                 baud_end;

    assign baud_end   = (baud_q == BAUD_LAST);
    assign fifo_read  = (state_q == S_IDLE) & enable & ~fifo_empty & ~RST;
    assign busy       = (state_q != S_IDLE);
    assign frame_done = (state_q == S_STOP) & baud_end;
    assign tx         = tx_q;

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        sreg_d    = sreg_q;
        case (state_q)
            S_IDLE: begin
                baud_d    = '0;
                bit_idx_d = '0;
                if (fifo_read) state_d = S_WAIT;
            end
            S_WAIT: begin
                sreg_d  = fifo_data;
                baud_d  = '0;
                state_d = S_START;
            end
            S_START: begin
                if (baud_end) begin
                    baud_d    = '0;
                    bit_idx_d = '0;
                    state_d   = S_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    sreg_d = sreg_q >> 1;
                    if (bit_idx_q == BIT_LAST) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_STOP: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                baud_d    = '0;
                bit_idx_d = '0;
                state_d   = S_IDLE;
            end
        endcase
    end

    // tx is registered from the next state so the line changes exactly on state/bit boundaries.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = sreg_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            sreg_q    <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            sreg_q    <= sreg_d;
            tx_q      <= tx_d;
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with 4 clocks per bit and a registered-output fifo model.
module tb_fifo_uart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [7:0] fdata;
    logic       fifo_empty;
    logic       fifo_read;
    logic       tx;
    logic       busy;
    logic       frame_done;

    logic [7:0] mem [0:63];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    int         rd_count = 0;
    int         vectors = 0;
    int         miscompares = 0;

    always #5 clk = ~clk;

    fifo_uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(4)) dut (
        .CLOCK_50  (clk),
        .RST       (rst),
        .enable    (enable),
        .fifo_data (fdata),
        .fifo_empty(fifo_empty),
        .fifo_read (fifo_read),
        .tx        (tx),
        .busy      (busy),
        .frame_done(frame_done)
    );

    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (fifo_read) begin
            fdata    <= mem[rd_ptr % 64];
            rd_ptr   <= rd_ptr + 1;
            rd_count <= rd_count + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr % 64] = b;
        wr_ptr++;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Leaves the bench in the cycle where fifo_read is high (cycle T).
    task automatic wait_read(input int max_cycles);
        int n = 0;
        #1;
        while (fifo_read !== 1'b1 && n < max_cycles) begin
            step();
            n++;
        end
        chk("read_seen", fifo_read, 1);
        chk("idle_busy", busy, 0);
        chk("idle_tx", tx, 1);
    endtask

    // Called in cycle T; returns in the last stop cycle (T+41).
    task automatic check_frame(input logic [7:0] b, input int drop_at);
        logic exp_tx;
        int   k;
        step();
        chk("wait_busy", busy, 1);
        chk("wait_tx", tx, 1);
        chk("wait_read", fifo_read, 0);
        for (int c = 0; c < 40; c++) begin
            step();
            if (c == drop_at) enable = 1'b0;
            k = c / 4;
            if (k == 0)      exp_tx = 1'b0;
            else if (k <= 8) exp_tx = b[k-1];
            else             exp_tx = 1'b1;
            chk("frame_tx", tx, exp_tx);
            chk("frame_done", frame_done, (c == 39));
            chk("frame_noread", fifo_read, 0);
            chk("frame_busy", busy, 1);
        end
    endtask

    task automatic frame_end(input logic exp_read);
        step();
        chk("end_busy", busy, 0);
        chk("end_tx", tx, 1);
        chk("end_read", fifo_read, exp_read);
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            chk("quiet_read", fifo_read, 0);
            chk("quiet_tx", tx, 1);
            chk("quiet_busy", busy, 0);
        end
    endtask

    initial begin
        int rd0;
        rst    = 1'b1;
        enable = 1'b1;
        push(8'hA5);

        // reset held with data queued
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rst_tx", tx, 1);
            chk("rst_busy", busy, 0);
            chk("rst_read", fifo_read, 0);
            chk("rst_done", frame_done, 0);
        end

        // single byte
        rst = 1'b0;
        wait_read(5);
        check_frame(8'hA5, -1);
        frame_end(0);
        quiet(3);

        // back-to-back frames, then fifo runs dry at the last frame end
        rd0 = rd_count;
        push(8'h00);
        push(8'hFF);
        push(8'h55);
        wait_read(5);
        check_frame(8'h00, -1);
        frame_end(1);
        check_frame(8'hFF, -1);
        frame_end(1);
        check_frame(8'h55, -1);
        frame_end(0);
        quiet(5);
        chk("b2b_reads", rd_count - rd0, 3);
        chk("b2b_empty", fifo_empty, 1);

        // enable low holds queued bytes; dropping it mid-frame does not truncate
        enable = 1'b0;
        push(8'h96);
        push(8'h0F);
        push(8'h3C);
        quiet(8);
        rd0 = rd_count;
        enable = 1'b1;
        wait_read(5);
        check_frame(8'h96, -1);
        frame_end(1);
        check_frame(8'h0F, 10);
        frame_end(0);
        quiet(6);
        chk("en_reads", rd_count - rd0, 2);
        chk("en_notempty", fifo_empty, 0);

        // reset during data bit 3 of 0x3C, then the next byte goes out cleanly
        push(8'hC3);
        enable = 1'b1;
        wait_read(5);
        for (int i = 0; i < 19; i++) step();
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_tx", tx, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_tx", tx, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_read", fifo_read, 0);
        step();
        chk("rst_hold_read", fifo_read, 0);
        step();
        rst = 1'b0;
        wait_read(5);
        check_frame(8'hC3, -1);
        frame_end(0);
        quiet(5);
        chk("final_empty", fifo_empty, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
